// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate unit: loads an operand, then applies one single-bit
// SLL/SRL/SRA/ROR step per clock for a latched number of steps, with a busy/done handshake.

// One bit position of the step network: SLL takes the lower neighbour, all
// right-moving modes take the upper neighbour (fill chosen by the parent).
module shift_seq_lane (
  input  logic [1:0] mode,
  input  logic       from_lo,
  input  logic       from_hi,
  output logic       q
);
  assign q = (mode == 2'b00) ? from_lo : from_hi;
endmodule

module shift_seq_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] a;
  } req_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] y_d;
  logic [AMT_W-1:0] cnt, cnt_d;
  logic [1:0]       mode_q, mode_d;
  req_t             req;

  logic [WIDTH-1:0] lo_nb, hi_nb, y_step;
  logic             fill;

  assign req = '{mode: mode, amt: amt, a: a};

  // Bit shifted into the MSB for the right-moving modes.
  always_comb begin
    fill = 1'b0;
    case (mode_q)
      2'b10:   fill = y[WIDTH-1];
      2'b11:   fill = y[0];
      default: fill = 1'b0;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (i == 0) begin : g_lo0
      assign lo_nb[i] = 1'b0;
    end else begin : g_lon
      assign lo_nb[i] = y[i-1];
    end
    if (i == WIDTH-1) begin : g_hitop
      assign hi_nb[i] = fill;
    end else begin : g_hin
      assign hi_nb[i] = y[i+1];
    end
    shift_seq_lane u_lane (
      .mode    (mode_q),
      .from_lo (lo_nb[i]),
      .from_hi (hi_nb[i]),
      .q       (y_step[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      y      <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
    end else begin
      state  <= state_d;
      y      <= y_d;
      cnt    <= cnt_d;
      mode_q <= mode_d;
    end
  end

  // DONE behaves like IDLE for start so back-to-back ops need no bubble.
  always_comb begin
    state_d = state;
    y_d     = y;
    cnt_d   = cnt;
    mode_d  = mode_q;
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          y_d     = req.a;
          cnt_d   = req.amt;
          mode_d  = req.mode;
          state_d = (req.amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          y_d   = y_step;
          cnt_d = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Randomized self-checking bench for shift_seq_unit against a result/timing reference model.
module tb_shift_seq_unit;
  localparam int W  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  y;
  logic          busy, done;

  int n_chk = 0;
  int n_fail = 0;

  shift_seq_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .amt(amt), .a(a), .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value after n single-bit steps, computed directly from the whole-word operation.
  function automatic logic [W-1:0] ref_y(logic [1:0] m, logic [W-1:0] v, int n);
    logic [W-1:0]   r;
    logic [2*W-1:0] d;
    case (m)
      2'b00:   r = v << n;
      2'b01:   r = v >> n;
      2'b10:   r = W'($signed(v) >>> n);
      default: begin d = {v, v} >> (n % W); r = d[W-1:0]; end
    endcase
    return r;
  endfunction

  // Starts at a negedge with the unit idle (or in its done cycle); returns at the
  // negedge of the done cycle. Checks y/busy/done every cycle.
  task automatic run_op(logic [1:0] m, int n, logic [W-1:0] av, bit poke);
    start = 1'b1; mode = m; amt = AW'(n); a = av;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); amt = AW'($urandom); a = W'($urandom);
    for (int c = 1; c <= n + 1; c++) begin
      chk("op_y", y, ref_y(m, av, c - 1));
      chk("op_busy", busy, c <= n);
      chk("op_done", done, c == n + 1);
      start = (poke && c == 1 && n >= 2);
      if (c <= n) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic idle_gap(logic [W-1:0] ey);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_y", y, ey);
  endtask

  // Abort asserted in SHIFT cycle k (1..n): k-1 steps have been applied.
  task automatic run_abort(logic [1:0] m, int n, logic [W-1:0] av, int k);
    start = 1'b1; mode = m; amt = AW'(n); a = av;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= k; c++) begin
      chk("ab_y", y, ref_y(m, av, c - 1));
      chk("ab_busy", busy, 1);
      abort = (c == k);
      @(negedge clk);
    end
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ab_post_y", y, ref_y(m, av, k - 1));
      chk("ab_post_busy", busy, 0);
      chk("ab_post_done", done, 0);
      if (c < 2) @(negedge clk);
    end
  endtask

  task automatic run_reset(logic [1:0] m, int n, logic [W-1:0] av);
    start = 1'b1; mode = m; amt = AW'(n); a = av;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rs_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_y", y, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rs_post_y", y, 0);
      chk("rs_post_busy", busy, 0);
      chk("rs_post_done", done, 0);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_y", y, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_hold_y", y, 0);

    run_op(2'b00, 1, 4'b1010, 0); chk("sll_1010_1", y, 4'b0100); idle_gap(4'b0100);
    run_op(2'b10, 2, 4'b1010, 0); chk("sra_1010_2", y, 4'b1110); idle_gap(4'b1110);
    run_op(2'b01, 2, 4'b1010, 0); chk("srl_1010_2", y, 4'b0010); idle_gap(4'b0010);
    run_op(2'b11, 1, 4'b1101, 0); chk("ror_1101_1", y, 4'b1110); idle_gap(4'b1110);
    run_op(2'b11, 5, 4'b1101, 0); chk("ror_1101_5", y, 4'b1110); idle_gap(4'b1110);
    run_op(2'b00, 0, 4'b0110, 0); chk("amt0_0110", y, 4'b0110); idle_gap(4'b0110);
    run_op(2'b00, 7, 4'b1111, 0); chk("sll_sat", y, 4'b0000); idle_gap(4'b0000);
    run_op(2'b10, 7, 4'b1001, 0); chk("sra_sat", y, 4'b1111); idle_gap(4'b1111);
    run_op(2'b01, 4, 4'b0110, 1); chk("srl_poke", y, 4'b0000);
    run_op(2'b11, 3, 4'b1000, 0); chk("b2b_ror", y, 4'b0001);
    run_op(2'b00, 0, 4'b0101, 0); chk("b2b_amt0", y, 4'b0101);
    run_op(2'b10, 2, 4'b0100, 0); chk("b2b_sra", y, 4'b0001); idle_gap(4'b0001);
    run_abort(2'b00, 5, 4'b0011, 3);
    run_reset(2'b11, 6, 4'b1011);

    for (int t = 0; t < 80; t++) begin
      logic [1:0]   m;
      int           n, act;
      logic [W-1:0] av;
      m   = 2'($urandom_range(0, 3));
      n   = int'($urandom_range(0, 7));
      av  = W'($urandom);
      act = int'($urandom_range(0, 9));
      if (act >= 6 && act <= 7 && n >= 1) begin
        run_abort(m, n, av, int'($urandom_range(1, n)));
      end else if (act >= 8 && n >= 3) begin
        run_reset(m, n, av);
      end else begin
        run_op(m, n, av, 1'($urandom));
        if ($urandom_range(0, 1) == 0) idle_gap(ref_y(m, av, n));
      end
    end
    idle_gap(y);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
